// File: rtl/uart_byte_receiver_if.sv
// Receive-side UART signal bundle: serial line in, framed byte and status out.
interface uart_byte_receiver_if;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;

  // master: line driver / byte consumer; slave: the receiver itself
  modport master (
    output rx_serial,
    input  rx_byte,
    input  rx_valid,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  rx_serial,
    output rx_byte,
    output rx_valid,
    output frame_error,
    output busy
  );
endinterface

// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver with mid-bit sampling, glitch rejection and break handling.
module uart_byte_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_byte_receiver_if.slave  rx_if
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_byte_q;
  logic            rx_valid_q;
  logic            frame_error_q;
  logic            rxs;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      sync_q        <= 2'b11;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], rx_if.rx_serial};
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // The detection cycle is count 0, so START begins at count 1.
          if (!rxs) begin
            state_q <= StStart;
            cnt_q   <= CntW'(1);
          end
        end
        StStart: begin
          if (cnt_q == HalfCnt) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxs ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == LastCnt) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rxs;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == LastCnt) begin
            cnt_q <= '0;
            // Leaving mid stop bit lets a back-to-back start edge be seen in time.
            if (rxs) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          cnt_q <= '0;
          if (rxs) begin
            state_q <= StIdle;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rx_if.rx_byte     = rx_byte_q;
  assign rx_if.rx_valid    = rx_valid_q;
  assign rx_if.frame_error = frame_error_q;
  assign rx_if.busy        = (state_q != StIdle);

endmodule
